// File: rtl/mult_sequencer.sv
// Shift-add 32x32->64 multiply sequencer that borrows the shared ALU32Bit.
// Signed operands are reduced to magnitudes first; the product is negated at the end.
module mult_sequencer #(
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Signed,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  input  logic [31:0] ALUResult,
  output logic [3:0]  ALUControl,
  output logic [31:0] ALU_A,
  output logic [31:0] ALU_B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, STEP, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d, neg_q, neg_d, busy_q, busy_d, done_q, done_d;
  logic        carry;
  logic [63:0] neg_prod;

  always_comb begin
    ALUControl = ALU_ADD;
    ALU_A      = '0;
    ALU_B      = '0;
    case (state_q)
      ABS_A: begin ALUControl = ALU_SUB; ALU_B = a_q; end
      ABS_B: begin ALUControl = ALU_SUB; ALU_B = b_q; end
      STEP:  begin ALU_A = hi_q; ALU_B = lo_q[0] ? m_q : '0; end
      default: ;
    endcase
  end

  // Carry out of the ALU add recovered by unsigned wrap detection.
  assign carry    = (ALUResult < hi_q);
  assign neg_prod = ~{hi_q, lo_q} + 64'd1;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: if (Start) begin
        a_d     = OpA;
        b_d     = OpB;
        sgn_d   = Signed;
        neg_d   = Signed & (OpA[31] ^ OpB[31]);
        hi_d    = '0;
        cnt_d   = '0;
        state_d = ABS_A;
      end
      ABS_A: begin
        m_d     = (sgn_q & a_q[31]) ? ALUResult : a_q;
        state_d = ABS_B;
      end
      ABS_B: begin
        lo_d    = (sgn_q & b_q[31]) ? ALUResult : b_q;
        state_d = STEP;
      end
      STEP: begin
        hi_d  = {carry, ALUResult[31:1]};
        lo_d  = {ALUResult[0], lo_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        if (neg_q) {hi_d, lo_d} = neg_prod;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle 32x32 -> 64-bit multiply controller that runs the shift-add algorithm through the shared ALU32Bit instead of a dedicated multiplier array. It drives the ALU's ALUControl/A/B ports and consumes ALUResult. It produces HI/LO for mult/multu in the EX stage and raises Busy so the hazard unit can stall the pipeline.

## Interface
Parameters:
- ALU_ADD, 4'b0010, ALU control code for addition
- ALU_SUB, 4'b0110, ALU control code for subtraction

Ports:
- Clk  input  1  system clock, rising-edge
- Reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- Start  input  1  request; sampled only in IDLE
- Signed  input  1  1 = mult (two's complement), 0 = multu
- OpA  input  32  multiplicand
- OpB  input  32  multiplier
- ALUResult  input  32  result from ALU32Bit
- ALUControl  output  4  to ALU32Bit
- ALU_A  output  32  to ALU32Bit A
- ALU_B  output  32  to ALU32Bit B
- Busy  output  1  high in every state except IDLE
- Done  output  1  one-cycle pulse, product valid
- Hi  output  32  product bits 63:32 (registered)
- Lo  output  32  product bits 31:0 (registered)

## Operation
- States: IDLE, ABS_A, ABS_B, STEP, FIX, DONE.
- IDLE: ALUControl=ALU_ADD, ALU_A=ALU_B=0. If Start=1, register OpA, OpB and Signed. Register Neg = Signed & (OpA[31]^OpB[31]). Clear Hi. Set step count to 0. Go to ABS_A.
- ABS_A: ALUControl=ALU_SUB, ALU_A=0, ALU_B=A_reg. If Signed & A_reg[31], M <= ALUResult; otherwise M <= A_reg. Go to ABS_B.
- ABS_B: same as ABS_A, applied to B_reg; result goes to Lo. Go to STEP. Both ABS states always execute, so latency is fixed.
- STEP, 32 iterations:
  - ALUControl=ALU_ADD, ALU_A=Hi, ALU_B = Lo[0] ? M : 0.
  - Carry = (ALUResult < Hi), unsigned compare done locally.
  - Hi <= {Carry, ALUResult[31:1]}; Lo <= {ALUResult[0], Lo[31:1]}; count++.
  - After count 31, go to FIX.
- FIX: if Neg, {Hi,Lo} <= ~{Hi,Lo} + 1 using a local 64-bit incrementer (no ALU use); otherwise hold. Go to DONE.
- DONE: Done=1 for this one cycle. Go to IDLE.
- Hi/Lo hold the last product until the next accepted Start.
- Magnitude of 0x80000000 is 0x80000000 (unsigned reading of 0-x), so no special case is needed.
- Zero output of ALU32Bit is unused.

## Timing
- Reset (async, any state): state=IDLE, Busy=0, Done=0, Hi=0, Lo=0, count=0, internal regs=0; ALU outputs take their IDLE values immediately.
- Start sampled at edge k: ABS_A during cycle k..k+1, ABS_B at k+1, STEP at k+2..k+33, FIX at k+34, DONE at k+35.
- Done is high between edges k+35 and k+36; Hi/Lo are final from edge k+35. Latency is 35 cycles.
- Busy rises after edge k and falls after edge k+36 (IDLE again).
- Start while Busy=1 is ignored, no queuing. Operand changes after edge k have no effect.
- Start high in the DONE cycle is ignored. Start high in the following IDLE cycle launches back-to-back (1 idle cycle minimum between ops).
- Reset mid-operation aborts: no Done pulse, Hi/Lo cleared.
- ALU is combinational, and its result is registered at the same edge it is consumed; no ALU pipeline delay is assumed.

## Test plan
- Reset, then multu 12 x 12 -> Done exactly 35 cycles after Start edge; Hi=0, Lo=144; Busy high for 36 cycles.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001 (exercises carry every step).
- mult -3 x 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; mult -5 x -6 -> Hi=0, Lo=30.
- mult 0x80000000 x 0x80000000 -> Hi=0x40000000, Lo=0; multu of the same -> Hi=0x40000000, Lo=0.
- Start pulsed again at step 10 with different operands -> ignored; first product unchanged, single Done pulse.
- Reset asserted asynchronously at step 20 -> Busy=0, Hi=Lo=0 immediately, no Done; a new Start afterwards completes normally.
